// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: key-load handshake and round-key read port of the
// AES-128 key-expansion engine. The engine side uses the slave modport, the
// key source / round datapath side uses the master modport.
interface aes_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         keys_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_o;

  modport master (
    output key_in,
    output key_valid,
    output rk_round,
    input  key_ready,
    input  keys_ready,
    input  rk_o
  );

  modport slave (
    input  key_in,
    input  key_valid,
    input  rk_round,
    output key_ready,
    output keys_ready,
    output rk_o
  );
endinterface

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion, one 32-bit word per
// cycle into 44 stored words (11 round keys), served through a registered
// read port indexed by round number.
// Optional build macro AES_KS_REVERSE_READ_EN: the read port returns
// key[10-rk_round] instead of key[rk_round]; expansion is identical.
module aes_key_schedule (
  input logic clk,
  input logic rst_n,
  aes_key_schedule_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte S-box lookup.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]  state;
  logic [5:0]  wcnt;
  logic [7:0]  rcon;
  logic        keys_ready_q;
  logic        accept;

  // Sliding window: win[0] = w[i-4] ... win[3] = w[i-1].
  logic [31:0] win [4];
  logic [31:0] key_mem [44];

  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] temp_w;
  logic [31:0] new_w;

  logic        rd_in_range;
  logic [3:0]  rd_round;
  logic [5:0]  rd_base;

  // Gating with rst_n keeps key_ready low for the whole reset assertion.
  assign bus.key_ready  = rst_n && ((state == S_IDLE) || (state == S_READY));
  assign bus.keys_ready = keys_ready_q;
  assign accept         = bus.key_valid && bus.key_ready;

  assign rot_w = {win[3][23:0], win[3][31:24]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sub
    assign sub_w[8*g +: 8] = sbox(rot_w[8*g +: 8]);
  end

  assign temp_w = (wcnt[1:0] == 2'b00) ? (sub_w ^ {rcon, 24'h0}) : win[3];
  assign new_w  = win[0] ^ temp_w;

  // Control FSM: accept a key, count words 4..43, then hold keys as readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wcnt         <= 6'd0;
      rcon         <= 8'h01;
      keys_ready_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (accept) begin
            state        <= S_EXPAND;
            wcnt         <= 6'd4;
            rcon         <= 8'h01;
            keys_ready_q <= 1'b0;
          end
        end
        S_EXPAND: begin
          if (wcnt[1:0] == 2'b00) begin
            rcon <= xtime(rcon);
          end
          if (wcnt == 6'd43) begin
            state        <= S_READY;
            keys_ready_q <= 1'b1;
          end
          wcnt <= wcnt + 6'd1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Word storage and window; contents need no reset, validity is keys_ready.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_mem[0] <= bus.key_in[127:96];
      key_mem[1] <= bus.key_in[95:64];
      key_mem[2] <= bus.key_in[63:32];
      key_mem[3] <= bus.key_in[31:0];
      win[0]     <= bus.key_in[127:96];
      win[1]     <= bus.key_in[95:64];
      win[2]     <= bus.key_in[63:32];
      win[3]     <= bus.key_in[31:0];
    end else if (state == S_EXPAND) begin
      key_mem[wcnt] <= new_w;
      win[0]        <= win[1];
      win[1]        <= win[2];
      win[2]        <= win[3];
      win[3]        <= new_w;
    end
  end

  // Read address: round index mapped to the first word of that round key.
  always_comb begin
    rd_in_range = (bus.rk_round <= 4'd10);
`ifdef AES_KS_REVERSE_READ_EN
    rd_round = 4'd10 - bus.rk_round;
`else
    rd_round = bus.rk_round;
`endif
    rd_base = rd_in_range ? {rd_round, 2'b00} : 6'd0;
  end

  // Registered read port; yields zero until keys are valid or when out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rk_o <= 128'h0;
    end else if (keys_ready_q && rd_in_range) begin
      bus.rk_o <= {key_mem[rd_base], key_mem[rd_base | 6'd1],
                   key_mem[rd_base | 6'd2], key_mem[rd_base | 6'd3]};
    end else begin
      bus.rk_o <= 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: randomized and directed bench for aes_key_schedule.
// The reference derives the S-box from GF(2^8) inversion plus the affine map,
// expands keys word by word, and tracks timing as a simple busy counter.
// Honours AES_KS_REVERSE_READ_EN in the same way as the design.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_if bus();

  aes_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [10:0][127:0] rks_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [7:0] sb [256];

  int         m_cnt = 0;
  bit         m_kr = 1'b0;
  logic [127:0] m_rk = '0;
  rks_t       m_keys = '0;
  rks_t       m_pend = '0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_gf(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic rks_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rks_t        res;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic int ridx(input logic [3:0] rr);
`ifdef AES_KS_REVERSE_READ_EN
    return 10 - int'(rr);
`else
    return int'(rr);
`endif
  endfunction

  function automatic logic [3:0] phys(input int lr);
`ifdef AES_KS_REVERSE_READ_EN
    return 4'(10 - lr);
`else
    return 4'(lr);
`endif
  endfunction

  // Reference timing: busy for 40 edges after an accept, then keys readable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_kr  <= 1'b0;
      m_rk  <= '0;
    end else begin
      m_rk <= (m_kr && bus.rk_round <= 4'd10) ? m_keys[ridx(bus.rk_round)] : '0;
      if (m_cnt == 0 && bus.key_valid) begin
        m_pend <= expand(bus.key_in);
        m_cnt  <= 40;
        m_kr   <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_kr   <= 1'b1;
          m_keys <= m_pend;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_key_ready", 128'(bus.key_ready), 128'(rst_n && (m_cnt == 0)));
      chk("cyc_keys_ready", 128'(bus.keys_ready), 128'(m_kr));
      chk("cyc_rk_o", bus.rk_o, m_rk);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.keys_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.keys_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_keys_ready timeout got=0 want=1");
    end
  endtask

  task automatic load_and_wait(input logic [127:0] k, output int n);
    bus.key_in = k;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    wait_ready(n);
  endtask

  task automatic read_chk(input string nm, input int lr, input logic [127:0] exp);
    bus.rk_round = phys(lr);
    step();
    chk(nm, bus.rk_o, exp);
  endtask

  task automatic random_reads(input int cnt);
    repeat (cnt) begin
      bus.rk_round = 4'($urandom_range(0, 15));
      step();
    end
  endtask

  initial begin
    int n;
    rks_t e;
    logic [127:0] k1, k2;
    for (int a = 0; a < 256; a++) sb[a] = sbox_gf(8'(a));
    bus.key_in = '0;
    bus.key_valid = 1'b0;
    bus.rk_round = 4'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    chk("rst_key_ready", 128'(bus.key_ready), 128'h0);
    chk("rst_keys_ready", 128'(bus.keys_ready), 128'h0);
    chk("rst_rk_o", bus.rk_o, 128'h0);

    // Pin the reference expansion to known vectors.
    e = expand(FIPS_KEY);
    chk("model_fips_r0", e[0], FIPS_KEY);
    chk("model_fips_r1", e[1], FIPS_R1);
    chk("model_fips_r10", e[10], FIPS_R10);
    e = expand(128'h0);
    chk("model_zero_r1", e[1], ZERO_R1);
    chk("model_zero_r10", e[10], ZERO_R10);

    rst_n = 1'b1;
    step();
    chk("idle_key_ready", 128'(bus.key_ready), 128'h1);

    // FIPS-197 key, latency and three rounds.
    load_and_wait(FIPS_KEY, n);
    chk("fips_latency", 128'(n), 128'd40);
    read_chk("fips_r0", 0, FIPS_KEY);
    read_chk("fips_r1", 1, FIPS_R1);
    read_chk("fips_r10", 10, FIPS_R10);
    random_reads(30);
    bus.rk_round = 4'd11;
    step();
    chk("oor_11", bus.rk_o, 128'h0);
    bus.rk_round = 4'd15;
    step();
    chk("oor_15", bus.rk_o, 128'h0);

    // All-zero key.
    load_and_wait(128'h0, n);
    read_chk("zero_r1", 1, ZERO_R1);
    read_chk("zero_r10", 10, ZERO_R10);

    // key_valid held through expansion with a changing key_in.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    bus.key_in = k1;
    bus.key_valid = 1'b1;
    step();
    repeat (39) begin
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("hold_key_ready", 128'(bus.key_ready), 128'h0);
    end
    bus.key_valid = 1'b0;
    wait_ready(n);
    chk("hold_latency", 128'(n), 128'd1);
    e = expand(k1);
    read_chk("hold_r0", 0, e[0]);
    read_chk("hold_r5", 5, e[5]);
    read_chk("hold_r10", 10, e[10]);

    // New key while READY: old keys invalid immediately.
    k2 = {$urandom, $urandom, $urandom, $urandom};
    bus.rk_round = phys(3);
    bus.key_in = k2;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    chk("reload_keys_ready_drop", 128'(bus.keys_ready), 128'h0);
    random_reads(10);
    wait_ready(n);
    e = expand(k2);
    read_chk("reload_r3", 3, e[3]);
    read_chk("reload_r9", 9, e[9]);

    // Back-to-back loads with key_valid held and random reads.
    bus.key_valid = 1'b1;
    repeat (100) begin
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      bus.rk_round = 4'($urandom_range(0, 15));
      step();
    end
    bus.key_valid = 1'b0;
    wait_ready(n);
    random_reads(20);

    // A few more random keys.
    repeat (3) begin
      load_and_wait({$urandom, $urandom, $urandom, $urandom}, n);
      chk("rand_latency", 128'(n), 128'd40);
      random_reads(15);
    end

    // Reset in the middle of expansion.
    bus.key_in = FIPS_KEY;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    repeat (19) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_key_ready", 128'(bus.key_ready), 128'h0);
    chk("midrst_keys_ready", 128'(bus.keys_ready), 128'h0);
    chk("midrst_rk_o", bus.rk_o, 128'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    load_and_wait(FIPS_KEY, n);
    chk("post_rst_latency", 128'(n), 128'd40);
    read_chk("post_rst_r10", 10, FIPS_R10);
    read_chk("post_rst_r0", 0, FIPS_KEY);
    random_reads(10);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key-expansion engine that sits directly upstream of the AES-128 round datapath. It accepts a 128-bit master key over a valid/ready handshake and expands it one 32-bit word per cycle into the 11 round keys, which it stores internally. Once expansion finishes, it serves any round key through a registered read port indexed by round number. The round datapath reads key r during its round-r AddRoundKey.

## Interface
Parameters: none (AES-128 only; Nk=4, Nr=10 fixed).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- key_in  in  128  master key; key_in[127:120] is key byte 0, w0 = key_in[127:96]
- key_valid  in  1  key_in is valid this cycle
- key_ready  out  1  engine can accept a key (IDLE or READY state)
- keys_ready  out  1  all 11 round keys are stored and readable
- rk_round  in  4  round-key index, 0..10
- rk_o  out  128  registered round key; {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]

## Operation
- States: IDLE, EXPAND, READY.
- IDLE:
  - key_ready=1, keys_ready=0.
  - Handshake (key_valid & key_ready) stores w0..w3, loads the sliding window with w0..w3, sets i=4 and rcon=8'h01, then goes to EXPAND.
- EXPAND:
  - key_ready=0. Each cycle computes w[i] = w[i-4] ^ temp.
  - temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i[1:0]==0; otherwise temp = w[i-1].
  - SubWord uses four instances of the codebase byte S-box.
  - w[i] is written to storage and shifted into the window.
  - rcon advances by xtime (rcon<<1, ^8'h1b on carry-out) after each use.
  - At i==43 the write completes and the FSM goes to READY. key_valid is ignored during EXPAND.
- READY:
  - key_ready=1, keys_ready=1.
  - A new handshake behaves exactly as in IDLE: keys_ready drops on the next edge and the old keys are invalid.
- Storage: 44×32-bit words, with no reset requirement on contents.
- Read port:
  - Every edge: rk_o <= (keys_ready && rk_round<=10) ? key[rk_round] : 128'h0.
  - The read is evaluated using keys_ready and rk_round as they are before the edge.
- Word counter i is 6 bits and never wraps; values 44..63 are unreachable.

## Timing
- Reset values:
  - key_ready=0 while rst_n is low, and 1 in the first cycle after release (IDLE).
  - keys_ready=0, rk_o=128'h0, state=IDLE, i=0, rcon=8'h01.
- Accept edge E0. Words w4..w43 are written on edges E1..E40. keys_ready=1 after E40, i.e. 40 cycles after accept.
- The next key can be accepted on the same edge at which keys_ready is first seen high (back-to-back throughput is 41 cycles per key).
- Read latency is 1 cycle from rk_round to rk_o. rk_round may change every cycle.
- Reset asserted mid-expansion aborts immediately: outputs go to their reset values and the partial key is discarded.

## Configuration
- AES_KS_REVERSE_READ_EN:
  - Defined: the read port returns key[10-rk_round] for rk_round<=10, so the decryption datapath can index rounds upward. Out-of-range rk_round and keys_ready=0 still yield 0.
  - Undefined: the read port returns key[rk_round]. The expansion itself is identical in both builds.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, read rounds 0,1,10 → rk_o = 2b7e151628aed2a6abf7158809cf4f3c, a0fafe1788542cb123a339392a6c7605, d014f9a8c9ee2589e13f0cc8b6630ca6. keys_ready rises exactly 40 cycles after accept.
- All-zero key → round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high through EXPAND with a changing key_in → no extra accept, key_ready=0 for 40 cycles, results match the first key.
- In READY, present a second key → keys_ready=0 on the next cycle, rk_o=0 until 40 cycles later, then the new keys. rk_round=11 or 15 → rk_o=0.
- Assert rst_n=0 at cycle 20 of EXPAND → all outputs reset immediately. Then load the FIPS key → correct round 10 key.
- With AES_KS_REVERSE_READ_EN, FIPS key, rk_round=0 → d014f9a8c9ee2589e13f0cc8b6630ca6; rk_round=10 → 2b7e151628aed2a6abf7158809cf4f3c.
